// File: rtl/button_event_if.sv
// Event delivery channel between the button decoder and the harness control logic.
// The decoder drives event_valid/event_code and the consumer answers with event_ready.
interface button_event_if;
   logic       event_valid;
   logic       event_ready;
   logic [1:0] event_code;

   modport master (output event_valid, output event_code, input event_ready);
   modport slave  (input event_valid, input event_code, output event_ready);
endinterface

// File: rtl/button_event_decoder.sv
// Button event decoder: turns the filtered active-low button level into
// SHORT / LONG / REPEAT / LONG_RELEASE events held in a one-entry valid/ready
// output register. It also counts presses and events lost to back-pressure.
// Optional feature macro: BUTTON_REPEAT_EN enables REPEAT events while held.
module button_event_decoder #(
   parameter int LONG_CYCLES   = 1000,
   parameter int REPEAT_CYCLES = 250
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic                  signal_in,
   button_event_if.master        ev,
   output logic                  held,
   output logic [15:0]           press_count,
   output logic [7:0]            drop_count
);

   localparam int CW = $clog2((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES) + 1;
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

   localparam logic [1:0] CODE_SHORT        = 2'd0;
   localparam logic [1:0] CODE_LONG         = 2'd1;
   localparam logic [1:0] CODE_LONG_RELEASE = 2'd3;

`ifdef BUTTON_REPEAT_EN
   localparam logic [1:0]    CODE_REPEAT = 2'd2;
   localparam logic [CW-1:0] REP_LAST    = CW'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } state_t;

   state_t        state;
   state_t        next_state;
   logic          sig_q;
   logic          fall;
   logic [CW-1:0] hold_cnt;
   logic [CW-1:0] next_hold;
   logic          issue;
   logic [1:0]    issue_code;

`ifdef BUTTON_REPEAT_EN
   logic [CW-1:0] rep_cnt;
   logic [CW-1:0] next_rep;
`endif

   // sig_q resets high so a button already held at reset release reads as a fresh press
   assign fall = sig_q & ~signal_in;

   // State register with the hold/repeat counters and the previous input sample
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         sig_q    <= 1'b1;
         hold_cnt <= '0;
         held     <= 1'b0;
`ifdef BUTTON_REPEAT_EN
         rep_cnt  <= '0;
`endif
      end else begin
         state    <= next_state;
         sig_q    <= signal_in;
         hold_cnt <= next_hold;
         held     <= (next_state != IDLE);
`ifdef BUTTON_REPEAT_EN
         rep_cnt  <= next_rep;
`endif
      end
   end

   // Press classification: next state, counter updates and which event (if any) to issue
   always_comb begin
      next_state = state;
      next_hold  = hold_cnt;
      issue      = 1'b0;
      issue_code = CODE_SHORT;
`ifdef BUTTON_REPEAT_EN
      next_rep   = rep_cnt;
`endif
      unique case (state)
         IDLE: begin
            if (fall) begin
               next_state = PRESSED;
               next_hold  = CW'(1);
            end
         end
         PRESSED: begin
            if (signal_in) begin
               issue      = 1'b1;
               issue_code = CODE_SHORT;
               next_state = IDLE;
            end else if (hold_cnt == LONG_LAST) begin
               issue      = 1'b1;
               issue_code = CODE_LONG;
               next_state = HELD;
`ifdef BUTTON_REPEAT_EN
               next_rep   = '0;
`endif
            end else begin
               next_hold = hold_cnt + CW'(1);
            end
         end
         HELD: begin
            if (signal_in) begin
               issue      = 1'b1;
               issue_code = CODE_LONG_RELEASE;
               next_state = IDLE;
`ifdef BUTTON_REPEAT_EN
            end else if (rep_cnt == REP_LAST) begin
               issue      = 1'b1;
               issue_code = CODE_REPEAT;
               next_rep   = '0;
            end else begin
               next_rep = rep_cnt + CW'(1);
`endif
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // One-entry output register: a new event loads only when the slot is free or being
   // accepted on this edge; otherwise it is discarded and counted as dropped
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         ev.event_valid <= 1'b0;
         ev.event_code  <= 2'd0;
         press_count    <= 16'd0;
         drop_count     <= 8'd0;
      end else begin
         if (issue) begin
            if (!ev.event_valid || ev.event_ready) begin
               ev.event_valid <= 1'b1;
               ev.event_code  <= issue_code;
            end else if (drop_count != 8'hFF) begin
               drop_count <= drop_count + 8'd1;
            end
            if (issue_code == CODE_SHORT || issue_code == CODE_LONG) begin
               press_count <= press_count + 16'd1;
            end
         end else if (ev.event_valid && ev.event_ready) begin
            ev.event_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=3.
// Expectations for REPEAT events follow BUTTON_REPEAT_EN in the same way as the design.
module tb_button_event_decoder;

   localparam int LONG_CYCLES   = 8;
   localparam int REPEAT_CYCLES = 3;

`ifdef BUTTON_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   typedef struct {
      logic        sig;
      logic        rdy;
      logic        v;
      logic [1:0]  code;
      logic        hld;
      logic [15:0] press;
      logic [7:0]  drop;
   } vec_t;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        signal_in = 1'b1;
   logic        held;
   logic [15:0] press_count;
   logic [7:0]  drop_count;
   int          checks = 0;
   int          failures = 0;
   int          exp_press;
   int          exp_drop;
   vec_t        vecs[14];

   button_event_if ev_if ();

   button_event_decoder #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
   ) dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .signal_in  (signal_in),
      .ev         (ev_if.master),
      .held       (held),
      .press_count(press_count),
      .drop_count (drop_count)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_output(input string name, input logic v, input logic [1:0] code,
                               input logic hld, input int press, input int drop);
      check_val({name, ".valid"}, 32'(ev_if.event_valid), 32'(v));
      if (v) check_val({name, ".code"}, 32'(ev_if.event_code), 32'(code));
      check_val({name, ".held"}, 32'(held), 32'(hld));
      check_val({name, ".press"}, 32'(press_count), press[31:0]);
      check_val({name, ".drop"}, 32'(drop_count), drop[31:0]);
   endtask

   task automatic apply_stimulus(input logic sig, input logic rdy);
      signal_in         = sig;
      ev_if.event_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Short press with ready high, then two short presses under back-pressure
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 16'd0, 8'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 16'd0, 8'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 16'd0, 8'd0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 16'd0, 8'd0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 16'd0, 8'd0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 16'd1, 8'd0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 16'd1, 8'd0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'd1, 8'd0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'd1, 8'd0};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 16'd2, 8'd0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 16'd2, 8'd0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 16'd2, 8'd0};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 16'd3, 8'd1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 16'd3, 8'd1};

      ev_if.event_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset", 1'b0, 2'd0, 1'b0, 0, 0);
      check_val("reset.code", 32'(ev_if.event_code), 32'd0);
      n_reset = 1'b1;

      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b1, 1'b1);
         check_output("idle", 1'b0, 2'd0, 1'b0, 0, 0);
      end

      for (int i = 0; i < 14; i++) begin
         apply_stimulus(vecs[i].sig, vecs[i].rdy);
         check_output($sformatf("vec%0d", i), vecs[i].v, vecs[i].code, vecs[i].hld,
                      int'(vecs[i].press), int'(vecs[i].drop));
      end
      exp_press = 3;
      exp_drop  = 1;

      // Long hold: LONG on the 8th low sample, REPEATs every 3 lows after it if enabled
      for (int k = 1; k <= 14; k++) begin
         apply_stimulus(1'b0, 1'b1);
         if (k == 8) exp_press++;
         check_output($sformatf("long%0d", k),
                      (k == 8) || (REP_EN && (k == 11 || k == 14)),
                      (k == 8) ? 2'd1 : 2'd2, 1'b1, exp_press, exp_drop);
      end
      apply_stimulus(1'b1, 1'b1);
      check_output("long_release", 1'b1, 2'd3, 1'b0, exp_press, exp_drop);
      apply_stimulus(1'b1, 1'b1);
      check_output("long_accepted", 1'b0, 2'd0, 1'b0, exp_press, exp_drop);

      // LONG held under back-pressure: the LONG_RELEASE is dropped and LONG stays put
      for (int k = 1; k <= 8; k++) begin
         apply_stimulus(1'b0, 1'b0);
         if (k == 8) exp_press++;
         check_output($sformatf("bp_long%0d", k), k == 8, 2'd1, 1'b1, exp_press, exp_drop);
      end
      apply_stimulus(1'b1, 1'b0);
      exp_drop++;
      check_output("bp_release_dropped", 1'b1, 2'd1, 1'b0, exp_press, exp_drop);
      apply_stimulus(1'b1, 1'b0);
      check_output("bp_kept", 1'b1, 2'd1, 1'b0, exp_press, exp_drop);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      check_output("bp_pressed", 1'b1, 2'd1, 1'b1, exp_press, exp_drop);
      // Issue on the same edge as the accept loads the new SHORT
      apply_stimulus(1'b1, 1'b1);
      exp_press++;
      check_output("same_edge_load", 1'b1, 2'd0, 1'b0, exp_press, exp_drop);
      apply_stimulus(1'b1, 1'b1);
      check_output("same_edge_accept", 1'b0, 2'd0, 1'b0, exp_press, exp_drop);

      // Drop counter saturation: one pending SHORT, then many dropped presses
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0);
      exp_press++;
      for (int i = 0; i < 260; i++) begin
         apply_stimulus(1'b0, 1'b0);
         apply_stimulus(1'b1, 1'b0);
         exp_press++;
         if (exp_drop < 255) exp_drop++;
      end
      check_output("drop_saturate", 1'b1, 2'd0, 1'b0, exp_press, exp_drop);
      check_val("drop_is_ff", 32'(drop_count), 32'hFF);

      // Asynchronous reset mid-press with an event still pending
      for (int k = 1; k <= 5; k++) apply_stimulus(1'b0, 1'b0);
      check_output("pre_reset", 1'b1, 2'd0, 1'b1, exp_press, exp_drop);
      #3;
      n_reset = 1'b0;
      #1;
      check_output("async_reset", 1'b0, 2'd0, 1'b0, 0, 0);
      check_val("async_reset.code", 32'(ev_if.event_code), 32'd0);
      ev_if.event_ready = 1'b1;
      @(posedge clk);
      #1;
      check_output("reset_held", 1'b0, 2'd0, 1'b0, 0, 0);
      n_reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         apply_stimulus(1'b0, 1'b1);
         check_output($sformatf("post_reset%0d", k), k == 8, 2'd1, 1'b1, (k == 8) ? 1 : 0, 0);
      end
      apply_stimulus(1'b1, 1'b1);
      check_output("post_reset_release", 1'b1, 2'd3, 1'b0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
